// File: rtl/uart_mem_bridge.sv
// Serial debug/boot bridge: 8N1 command frames on rx become 32-bit bus reads/writes,
// replies go back on tx while cpu_hold stalls the core.
module uart_mem_bridge #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_valid,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        cpu_hold
);

  localparam int TW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_MEM, P_RESP} p_state_e;

  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [TW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            byte_valid_s, frame_err_s;

  p_state_e        p_state_q, p_state_d;
  logic            op_we_q, op_we_d;
  logic            nak_q, nak_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_valid_q, mem_valid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            tx_q, tx_d;
  logic            tx_busy_q, tx_busy_d;
  logic [TW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [1:0]      resp_idx_q, resp_idx_d;
  logic [7:0]      resp_byte_s;
  logic [1:0]      resp_last_s;

  // rx synchronizer plus one extra stage for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX frame engine: mid-bit sampling, glitch reject on the start bit
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_s = 1'b0;
    frame_err_s  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = 3'd0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
        else                         rx_state_d = RX_IDLE;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_state_d = RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d     = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_s = rx_sync_q;
          frame_err_s  = !rx_sync_q;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    resp_last_s = (!nak_q && !op_we_q) ? 2'd3 : 2'd0;
    if (nak_q) begin
      resp_byte_s = 8'h15;
    end else if (op_we_q) begin
      resp_byte_s = 8'h06;
    end else begin
      case (resp_idx_q)
        2'd0:    resp_byte_s = rdata_q[7:0];
        2'd1:    resp_byte_s = rdata_q[15:8];
        2'd2:    resp_byte_s = rdata_q[23:16];
        default: resp_byte_s = rdata_q[31:24];
      endcase
    end
  end

  // Command parser, bus initiator and reply transmitter
  always_comb begin
    p_state_d   = p_state_q;
    op_we_d     = op_we_q;
    nak_d       = nak_q;
    byte_cnt_d  = byte_cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    mem_valid_d = mem_valid_q;
    rdata_d     = rdata_q;
    cpu_hold_d  = cpu_hold_q;
    tx_d        = tx_q;
    tx_busy_d   = tx_busy_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    resp_idx_d  = resp_idx_q;
    case (p_state_q)
      P_IDLE: begin
        if (byte_valid_s) begin
          cpu_hold_d = 1'b1;
          byte_cnt_d = 2'd0;
          resp_idx_d = 2'd0;
          nak_d      = 1'b0;
          if (rx_shift_q == 8'h57) begin
            op_we_d   = 1'b1;
            p_state_d = P_ADDR;
          end else if (rx_shift_q == 8'h52) begin
            op_we_d   = 1'b0;
            p_state_d = P_ADDR;
          end else begin
            nak_d     = 1'b1;
            p_state_d = P_RESP;
          end
        end else begin
          p_state_d = P_IDLE;
        end
      end
      P_ADDR, P_DATA: begin
        if (frame_err_s) begin
          nak_d     = 1'b1;
          p_state_d = P_RESP;
        end else if (byte_valid_s) begin
          if (p_state_q == P_ADDR) mem_addr_d[{byte_cnt_q, 3'b000} +: 8]  = rx_shift_q;
          else                     mem_wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_shift_q;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == 2'd3) begin
            if (p_state_q == P_ADDR && op_we_q) begin
              p_state_d = P_DATA;
            end else begin
              p_state_d   = P_MEM;
              mem_valid_d = 1'b1;
              mem_we_d    = op_we_q;
            end
          end
        end else begin
          p_state_d = p_state_q;
        end
      end
      P_MEM: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          p_state_d   = P_RESP;
          if (!op_we_q) rdata_d = mem_rdata;
          else          rdata_d = rdata_q;
        end else begin
          p_state_d = P_MEM;
        end
      end
      P_RESP: begin
        if (!tx_busy_q) begin
          tx_busy_d = 1'b1;
          tx_bit_d  = 4'd0;
          tx_cnt_d  = '0;
          tx_d      = 1'b0;
        end else if (tx_cnt_q != BIT_LAST) begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end else begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            if (resp_idx_q == resp_last_s) begin
              p_state_d  = P_IDLE;
              cpu_hold_d = 1'b0;
              tx_busy_d  = 1'b0;
              resp_idx_d = 2'd0;
              tx_d       = 1'b1;
            end else begin
              // next reply byte starts straight after this stop bit
              resp_idx_d = resp_idx_q + 1'b1;
              tx_bit_d   = 4'd0;
              tx_d       = 1'b0;
            end
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            tx_d     = (tx_bit_q == 4'd8) ? 1'b1 : resp_byte_s[tx_bit_q[2:0]];
          end
        end
      end
      default: p_state_d = P_IDLE;
    endcase
  end

  // State registers for the RX engine and the parser/transmitter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      p_state_q   <= P_IDLE;
      op_we_q     <= 1'b0;
      nak_q       <= 1'b0;
      byte_cnt_q  <= 2'd0;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_we_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      cpu_hold_q  <= 1'b0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 4'd0;
      resp_idx_q  <= 2'd0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      p_state_q   <= p_state_d;
      op_we_q     <= op_we_d;
      nak_q       <= nak_d;
      byte_cnt_q  <= byte_cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_valid_q <= mem_valid_d;
      rdata_q     <= rdata_d;
      cpu_hold_q  <= cpu_hold_d;
      tx_q        <= tx_d;
      tx_busy_q   <= tx_busy_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      resp_idx_q  <= resp_idx_d;
    end
  end

  assign tx        = tx_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_valid = mem_valid_q;
  assign cpu_hold  = cpu_hold_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Directed bench for uart_mem_bridge: scoreboard queues for bus requests and reply bytes.
module tb_uart_mem_bridge;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        tx, mem_we, mem_valid, cpu_hold;
  logic [31:0] mem_addr, mem_wdata;

  uart_mem_bridge #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } bus_t;

  int          n_total = 0;
  int          n_pass = 0;
  int unsigned cyc = 0;
  int unsigned last_start_cyc = 0;
  logic [7:0]  tx_exp_q[$];
  bus_t        bus_exp_q[$];
  int          mv_rises = 0;
  int unsigned mv_rise_cyc = 0;
  logic        mv_prev = 1'b0;
  int          dec_bytes = 0;
  int unsigned dec_starts[$];
  logic        dec_active = 1'b0;
  int          dec_cnt = 0;
  logic [7:0]  dec_sr = 8'h00;
  logic        tx_prev = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(negedge clk) begin
    if (mem_valid && !mv_prev) begin
      mv_rises    <= mv_rises + 1;
      mv_rise_cyc <= cyc;
    end
    mv_prev <= mem_valid;
  end

  // tx frame decoder: samples each bit at its centre, pops expected bytes
  always @(negedge clk) begin
    if (rst) begin
      dec_active <= 1'b0;
      tx_prev    <= 1'b1;
    end else begin
      tx_prev <= tx;
      if (!dec_active) begin
        if (tx_prev && !tx) begin
          dec_active <= 1'b1;
          dec_cnt    <= 1;
          dec_starts.push_back(cyc);
        end
      end else begin
        dec_cnt <= dec_cnt + 1;
        if ((dec_cnt % CPB) == CPB / 2) begin
          if (dec_cnt / CPB == 0) begin
            check("tx_start_bit", 32'(tx), 32'd0);
          end else if (dec_cnt / CPB <= 8) begin
            dec_sr[dec_cnt / CPB - 1] <= tx;
          end else begin
            check("tx_stop_bit", 32'(tx), 32'd1);
            if (tx_exp_q.size() == 0) check("tx_unexpected_byte", 32'(dec_sr), 32'hFFFF_FFFF);
            else                      check("tx_byte", 32'(dec_sr), 32'(tx_exp_q.pop_front()));
            dec_bytes  <= dec_bytes + 1;
            dec_active <= 1'b0;
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    last_start_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] addr);
    send_frame(op, 1'b1);
    for (int i = 0; i < 4; i++) send_frame(addr[8*i +: 8], 1'b1);
  endtask

  task automatic push_bus(input logic [31:0] a, input logic [31:0] d, input logic we);
    bus_t t;
    t.addr = a; t.wdata = d; t.we = we;
    bus_exp_q.push_back(t);
  endtask

  // hold off mem_ready for `waits` cycles, checking the request is stable, then accept
  task automatic do_bus(input int waits, input logic [31:0] rdata);
    bus_t e;
    e = bus_exp_q.pop_front();
    if (e.we) tx_exp_q.push_back(8'h06);
    else for (int i = 0; i < 4; i++) tx_exp_q.push_back(rdata[8*i +: 8]);
    for (int i = 0; i <= waits; i++) begin
      check("bus_valid", 32'(mem_valid), 32'd1);
      check("bus_addr", mem_addr, e.addr);
      check("bus_wdata", mem_wdata, e.wdata);
      check("bus_we", 32'(mem_we), 32'(e.we));
      check("bus_hold", 32'(cpu_hold), 32'd1);
      if (i == waits) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    check("bus_valid_drop", 32'(mem_valid), 32'd0);
  endtask

  task automatic wait_reply(input string tag);
    for (int i = 0; i < 3000 && tx_exp_q.size() != 0; i++) @(negedge clk);
    check(tag, 32'(tx_exp_q.size()), 32'd0);
    check("hold_during_stop", 32'(cpu_hold), 32'd1);
    repeat (12) @(negedge clk);
    check("hold_released", 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    int rises0;
    int bytes0;
    int n;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_valid", 32'(mem_valid), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // write 0xDEADBEEF to 0x10
    rises0 = mv_rises;
    push_bus(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    send_frame(8'h57, 1'b1);
    check("wr_hold_after_cmd", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 4; i++) send_frame(8'h10 >> (8 * i), 1'b1);
    send_frame(8'hEF, 1'b1);
    send_frame(8'hBE, 1'b1);
    send_frame(8'hAD, 1'b1);
    send_frame(8'hDE, 1'b1);
    check("wr_valid_rise_cycle", mv_rise_cyc, last_start_cyc + 32'd3 + CPB / 2 + 9 * CPB);
    check("wr_one_request", 32'(mv_rises - rises0), 32'd1);
    do_bus(1, 32'h0);
    wait_reply("wr_ack_done");

    // read with five wait states, reply must be four back-to-back bytes
    push_bus(32'h8000_0004, 32'hDEAD_BEEF, 1'b0);
    send_cmd(8'h52, 32'h8000_0004);
    do_bus(5, 32'h1234_5678);
    wait_reply("rd_reply_done");
    n = dec_starts.size();
    for (int i = 1; i < 4; i++)
      check("rd_byte_spacing", dec_starts[n - i] - dec_starts[n - i - 1], 32'd160);

    // unknown command -> NAK, then a normal read
    rises0 = mv_rises;
    tx_exp_q.push_back(8'h15);
    send_frame(8'h41, 1'b1);
    wait_reply("nak_unknown_done");
    check("nak_no_request", 32'(mv_rises - rises0), 32'd0);
    push_bus(32'h0000_0100, 32'hDEAD_BEEF, 1'b0);
    send_cmd(8'h52, 32'h0000_0100);
    do_bus(0, 32'hCAFE_F00D);
    wait_reply("rd_after_nak_done");

    // 8-cycle glitch must not produce a byte
    bytes0 = dec_bytes;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_no_hold", 32'(cpu_hold), 32'd0);
    check("glitch_no_reply", 32'(dec_bytes - bytes0), 32'd0);

    // framing error inside the address phase
    rises0 = mv_rises;
    tx_exp_q.push_back(8'h15);
    send_frame(8'h57, 1'b1);
    send_frame(8'h10, 1'b0);
    repeat (4) @(negedge clk);
    wait_reply("frame_nak_done");
    check("frame_no_request", 32'(mv_rises - rises0), 32'd0);

    // extra byte arriving while the bus request is pending is dropped
    rises0 = mv_rises;
    bytes0 = dec_bytes;
    push_bus(32'h0000_0020, 32'hDEAD_BEEF, 1'b0);
    send_cmd(8'h52, 32'h0000_0020);
    send_frame(8'h55, 1'b1);
    check("extra_still_valid", 32'(mem_valid), 32'd1);
    do_bus(2, 32'hA5A5_5A5A);
    wait_reply("extra_reply_done");
    check("extra_one_request", 32'(mv_rises - rises0), 32'd1);
    check("extra_reply_len", 32'(dec_bytes - bytes0), 32'd4);

    // reset in the middle of the second reply byte
    push_bus(32'h0000_0044, 32'hDEAD_BEEF, 1'b0);
    send_cmd(8'h52, 32'h0000_0044);
    do_bus(0, 32'h1122_3344);
    bytes0 = dec_bytes;
    for (int i = 0; i < 400 && dec_bytes == bytes0; i++) @(negedge clk);
    check("rstmid_first_byte", 32'(dec_bytes - bytes0), 32'd1);
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_tx", 32'(tx), 32'd1);
    check("rstmid_hold", 32'(cpu_hold), 32'd0);
    tx_exp_q.delete();
    bytes0 = dec_bytes;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (700) @(negedge clk);
    check("rstmid_no_more_bytes", 32'(dec_bytes - bytes0), 32'd0);
    check("rstmid_tx_idle", 32'(tx), 32'd1);

    // write after reset completes normally
    push_bus(32'h0000_0008, 32'h1234_5678, 1'b1);
    send_cmd(8'h57, 32'h0000_0008);
    for (int i = 0; i < 4; i++) send_frame(8'(32'h1234_5678 >> (8 * i)), 1'b1);
    do_bus(0, 32'h0);
    wait_reply("post_rst_wr_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
- Host-side serial debug/boot bridge: receives 8N1 command frames on `rx`, performs 32-bit memory reads and writes as a bus initiator, and returns replies on `tx`.
- It is the initiator counterpart of the memory-mapped UART peripheral. It lets a PC load programs into RAM and inspect memory.
- `cpu_hold` stalls the core while a command is in flight.

Parameters:
- CLKS_PER_BIT, 10417: clock cycles per serial bit. Legal values are ≥ 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial in; idles high; asynchronous to `clk`.
- tx  output  1  serial out; idles high.
- mem_addr  output  32  bus address.
- mem_wdata  output  32  write data.
- mem_we  output  1  1 = write, 0 = read; valid while `mem_valid` is high.
- mem_valid  output  1  bus request.
- mem_ready  input  1  target accepts the request on a `clk` edge where `mem_valid` and `mem_ready` are both 1.
- mem_rdata  input  32  read data; sampled on the accepting edge.
- cpu_hold  output  1  high from acceptance of a command byte until the last reply stop bit ends.

Behaviour:
- Reset values: `tx`=1, `mem_valid`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0. RX, TX and parser state machines all go to IDLE; the bit counter clears.
- Reset mid-frame or mid-bus-cycle aborts immediately. No partial reply is sent after reset.

RX path:
- `rx` passes through a 2-flop synchronizer.
- A falling edge in RX IDLE starts a counter.
- At CLKS_PER_BIT/2 the start bit is re-checked. If it reads 1, the event is a glitch: return to IDLE with no byte.
- Data bits are sampled every CLKS_PER_BIT thereafter, 8 of them, LSB first, then the stop bit.
- Stop bit = 1: one-cycle `byte_valid` is presented to the parser.
- Stop bit = 0: framing error, flagged to the parser, no byte.
- RX returns to IDLE at the stop-bit sample point.

Parser FSM: IDLE → ADDR → DATA → MEM → RESP → IDLE.
- IDLE:
  - 0x57 ('W') sets op=write and goes to ADDR.
  - 0x52 ('R') sets op=read and goes to ADDR.
  - Any other byte queues NAK 0x15 and goes to RESP.
  - `cpu_hold` asserts on the same edge the byte is accepted.
- ADDR: collects 4 bytes, LSB first, into `mem_addr`. After the 4th byte, a write goes to DATA and a read goes to MEM.
- DATA: collects 4 bytes, LSB first, into `mem_wdata`, then goes to MEM.
- MEM:
  - `mem_valid`=1 and `mem_we`=op from the first cycle in MEM, i.e. one cycle after the last payload `byte_valid`.
  - Address, data and `mem_we` are held stable until handshake. Wait for `mem_ready` indefinitely; there is no timeout.
  - On handshake: `mem_valid` drops next cycle. A read latches `mem_rdata`. Then go to RESP.
- RESP: transmits the reply, then returns to IDLE and deasserts `cpu_hold` on the cycle after the final stop bit completes.
  - Write: ACK 0x06.
  - Read: 4 bytes of read data, LSB byte first.
  - NAK: 0x15.
- Framing error in ADDR or DATA: discard the partial command and go to RESP with NAK.
- Bytes completing during MEM or RESP are discarded silently. The RX engine keeps running so it stays frame-aligned.
- `mem_addr` and `mem_wdata` retain their last values when idle.

TX path:
- Start TX on the cycle after entering RESP or after the previous byte's stop bit.
- Frame: start 0, 8 data bits LSB first, stop 1. Each bit is exactly CLKS_PER_BIT cycles.
- Consecutive reply bytes are back-to-back with no idle gap.
- The TX bit timer is independent of the RX timer; full duplex is permitted.

Width rules:
- Byte counters are 2 bits.
- The bit timer is sized `$clog2(CLKS_PER_BIT)`+1. It counts 0..CLKS_PER_BIT-1 and wraps.

Test Plan (CLKS_PER_BIT=16, bench drives `mem_ready` and `mem_rdata`):
- Write: send 57 10 00 00 00 EF BE AD DE → one `mem_valid` pulse train with `mem_addr`=0x00000010, `mem_wdata`=0xDEADBEEF, `mem_we`=1; `mem_valid` rises exactly 1 cycle after the 9th stop-bit sample; `tx` then sends 0x06; `cpu_hold` is high throughout and low after the ACK stop bit.
- Read with wait states: send 52 04 00 00 80, hold `mem_ready`=0 for 5 cycles, then 1 with `mem_rdata`=0x12345678 → `mem_we`=0 and address 0x80000004 are stable for all 6 cycles; `tx` sends 78 56 34 12, back-to-back, each byte 160 cycles.
- Unknown command 0x41 → NAK 0x15; no `mem_valid`; parser back in IDLE. A following valid 'R' command is then serviced normally.
- Glitch and framing: an 8-cycle low pulse on `rx` produces no byte. A 'W' followed by an address byte with stop bit 0 produces NAK 0x15 and no bus cycle.
- Extra bytes: send 0x55 while in MEM (with `mem_ready` held low) → the byte is ignored; the reply is unchanged.
- Async reset asserted during a read's 2nd reply byte → `tx`=1 and `cpu_hold`=0 immediately; no remaining bytes are sent. After release, a 'W' command completes normally.
